// File: rtl/text_mem_loader_pkg.sv
// Shared definitions for the boot-time text memory loader: frame field
// widths, default geometry, FSM state encodings and a sizing helper.
package text_mem_loader_pkg;

  // Default text memory geometry and frame marker.
  localparam int unsigned DEF_TEXT_BASE  = 32'h800;
  localparam int unsigned DEF_ADDR_WIDTH = 12;
  localparam logic [7:0]  FRAME_SYNC     = 8'hA5;

  // Frame field widths.
  localparam int CNT_W  = 16;
  localparam int CSUM_W = 8;

  // Loader FSM state encodings.
  localparam int STATE_W = 4;
  localparam logic [STATE_W-1:0] ST_IDLE = 4'd0;
  localparam logic [STATE_W-1:0] ST_SYNC = 4'd1;
  localparam logic [STATE_W-1:0] ST_LEN0 = 4'd2;
  localparam logic [STATE_W-1:0] ST_LEN1 = 4'd3;
  localparam logic [STATE_W-1:0] ST_DATA = 4'd4;
  localparam logic [STATE_W-1:0] ST_WR   = 4'd5;
  localparam logic [STATE_W-1:0] ST_CSUM = 4'd6;
  localparam logic [STATE_W-1:0] ST_DONE = 4'd7;
  localparam logic [STATE_W-1:0] ST_ERR  = 4'd8;

  // Number of words between the first instruction word and the top of
  // the text memory; a frame with a larger count cannot fit.
  function automatic int unsigned free_words(input int unsigned addr_width,
                                             input int unsigned text_base);
    return (32'd1 << addr_width) - (text_base >> 2);
  endfunction

endpackage

// File: rtl/text_mem_loader_word_assembler.sv
// Assembles little-endian 32-bit words from a byte stream and keeps a
// running XOR checksum over every byte it is given.
module text_mem_loader_word_assembler
  import text_mem_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clear_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  output logic [31:0]       word_o,
  output logic [CSUM_W-1:0] csum_o,
  output logic              word_ready_o
);

  logic [1:0]        idx_q, idx_d;
  logic [31:0]       word_q, word_d;
  logic [CSUM_W-1:0] csum_q, csum_d;

  // Next byte index, word contents and checksum.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    idx_d  = idx_q;
    word_d = word_q;
    csum_d = csum_q;
    if (clear_i) begin
      idx_d  = '0;
      word_d = '0;
      csum_d = '0;
    end else if (byte_valid_i) begin
      word_d[8*idx_q +: 8] = byte_i;
      csum_d               = csum_q ^ byte_i;
      idx_d                = idx_q + 2'd1;
    end
  end

  // Assembler registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (!rst_n_i) begin
      idx_q  <= '0;
      word_q <= '0;
      csum_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
      csum_q <= csum_d;
    end
  end

  // The fourth byte completes the word; it is in word_o from the next cycle.
  assign word_ready_o = byte_valid_i && !clear_i && (idx_q == 2'd3);
  assign word_o       = word_q;
  assign csum_o       = csum_q;

endmodule

// File: rtl/text_mem_loader.sv
// Boot-time text memory writer: receives a framed byte stream, writes the
// assembled words from TEXT_BASE upward and holds the core in reset until
// a complete frame with a good checksum has been stored.
module text_mem_loader
  import text_mem_loader_pkg::*;
#(
  parameter int unsigned TEXT_BASE  = DEF_TEXT_BASE,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter logic [7:0]  SYNC_BYTE  = FRAME_SYNC
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  output logic                  w_en_o,
  output logic [ADDR_WIDTH-1:0] w_addr_o,
  output logic [31:0]           w_data_o,
  output logic                  core_hold_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o
);

  localparam int CNT_EXT_W = CNT_W + 1;
  localparam logic [ADDR_WIDTH-1:0] FIRST_WORD = ADDR_WIDTH'(TEXT_BASE >> 2);
  localparam logic [CNT_EXT_W-1:0]  MAX_WORDS  =
    CNT_EXT_W'(free_words(ADDR_WIDTH, TEXT_BASE));

  logic [STATE_W-1:0]    state_q, state_d;
  logic [7:0]            cnt_lo_q, cnt_lo_d;
  logic [CNT_W-1:0]      remaining_q, remaining_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;

  logic              rx_fire;
  logic              start_fire;
  logic [CNT_W-1:0]  frame_count;
  logic [31:0]       asm_word;
  logic [CSUM_W-1:0] asm_csum;
  logic              asm_word_ready;

  assign rx_fire     = rx_valid_i && rx_ready_o;
  assign start_fire  = start_i && (state_q == ST_IDLE || state_q == ST_DONE ||
                                   state_q == ST_ERR);
  assign frame_count = {rx_data_i, cnt_lo_q};

  text_mem_loader_word_assembler u_word_assembler (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .clear_i      (start_fire),
    .byte_valid_i (rx_fire && state_q == ST_DATA),
    .byte_i       (rx_data_i),
    .word_o       (asm_word),
    .csum_o       (asm_csum),
    .word_ready_o (asm_word_ready)
  );

  // Frame FSM with word count and write address bookkeeping.
  always_comb begin
    state_d     = state_q;
    cnt_lo_d    = cnt_lo_q;
    remaining_d = remaining_q;
    w_addr_d    = w_addr_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_i) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        // Anything other than the marker is consumed and dropped.
        if (rx_fire && rx_data_i == SYNC_BYTE) state_d = ST_LEN0;
      end
      ST_LEN0: begin
        if (rx_fire) begin
          cnt_lo_d = rx_data_i;
          state_d  = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (rx_fire) begin
          if ({1'b0, frame_count} > MAX_WORDS) begin
            state_d = ST_ERR;
          end else if (frame_count == '0) begin
            state_d = ST_CSUM;
          end else begin
            remaining_d = frame_count;
            w_addr_d    = FIRST_WORD;
            state_d     = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (asm_word_ready) state_d = ST_WR;
      end
      ST_WR: begin
        remaining_d = remaining_q - CNT_W'(1);
        if (remaining_q == CNT_W'(1)) begin
          // Last word: the address is left on it, so a frame that fills
          // the memory to the top never rolls the address over.
          state_d = ST_CSUM;
        end else begin
          w_addr_d = w_addr_q + ADDR_WIDTH'(1);
          state_d  = ST_DATA;
        end
      end
      ST_CSUM: begin
        if (rx_fire) state_d = (rx_data_i == asm_csum) ? ST_DONE : ST_ERR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Loader registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      cnt_lo_q    <= '0;
      remaining_q <= '0;
      w_addr_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_lo_q    <= cnt_lo_d;
      remaining_q <= remaining_d;
      w_addr_q    <= w_addr_d;
    end
  end

  // Outputs decode the registered state; DONE and ERROR are sticky because
  // their states are left only on START or reset.
  assign rx_ready_o  = (state_q == ST_SYNC) || (state_q == ST_LEN0) ||
                       (state_q == ST_LEN1) || (state_q == ST_DATA) ||
                       (state_q == ST_CSUM);
  assign busy_o      = rx_ready_o || (state_q == ST_WR);
  assign w_en_o      = (state_q == ST_WR);
  assign w_addr_o    = w_addr_q;
  assign w_data_o    = asm_word;
  // The core stays held through a failed load so it never runs a bad image.
  assign core_hold_o = !(state_q == ST_IDLE || state_q == ST_DONE);
  assign done_o      = (state_q == ST_DONE);
  assign error_o     = (state_q == ST_ERR);

endmodule

// File: tb/tb_text_mem_loader.sv
// Directed bench for text_mem_loader with a write scoreboard.
module tb_text_mem_loader;

  localparam int AW = 12;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          start    = 1'b0;
  logic [7:0]    rx_data  = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          w_en;
  logic [AW-1:0] w_addr;
  logic [31:0]   w_data;
  logic          core_hold;
  logic          busy;
  logic          done;
  logic          error;

  always #5 clk = ~clk;

  text_mem_loader #(
    .TEXT_BASE  (32'h800),
    .ADDR_WIDTH (AW),
    .SYNC_BYTE  (8'hA5)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .start_i     (start),
    .rx_data_i   (rx_data),
    .rx_valid_i  (rx_valid),
    .rx_ready_o  (rx_ready),
    .w_en_o      (w_en),
    .w_addr_o    (w_addr),
    .w_data_o    (w_data),
    .core_hold_o (core_hold),
    .busy_o      (busy),
    .done_o      (done),
    .error_o     (error)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t  exp_q[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   wen_count = 0;
  bit   rand_gaps = 1'b0;
  logic [31:0] frame_w [2] = '{32'h00150513, 32'h00253593};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe is counted and matched in order.
  always @(negedge clk) begin
    if (w_en === 1'b1) begin
      wen_count++;
      if (exp_q.size() > 0) begin
        wr_t e;
        e = exp_q.pop_front();
        check("w_addr", 64'(w_addr), 64'(e.addr));
        check("w_data", 64'(w_data), 64'(e.data));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] frame_csum();
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < 2; i++)
      c ^= frame_w[i][7:0] ^ frame_w[i][15:8] ^ frame_w[i][23:16] ^ frame_w[i][31:24];
    return c;
  endfunction

  // Called at a negedge; returns at the negedge after the handshake.
  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    if (rand_gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("rx_ready_wait", 64'(rx_ready), 64'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rx_ready"},  64'(rx_ready),  64'd0);
    check({tag, "_w_en"},      64'(w_en),      64'd0);
    check({tag, "_w_addr"},    64'(w_addr),    64'd0);
    check({tag, "_w_data"},    64'(w_data),    64'd0);
    check({tag, "_core_hold"}, 64'(core_hold), 64'd0);
    check({tag, "_busy"},      64'(busy),      64'd0);
    check({tag, "_done"},      64'(done),      64'd0);
    check({tag, "_error"},     64'(error),     64'd0);
  endtask

  // Two-word frame; expected writes are queued just before their bytes.
  task automatic send_frame1(input logic [7:0] flip, input int start_at);
    wr_t e;
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    for (int w = 0; w < 2; w++) begin
      e.addr = AW'(12'h200 + w);
      e.data = frame_w[w];
      exp_q.push_back(e);
      for (int b = 0; b < 4; b++) begin
        if (w * 4 + b == start_at) pulse_start();
        send_byte(frame_w[w][8*b +: 8]);
      end
    end
    check("hold_before_csum", 64'(core_hold), 64'd1);
    check("done_before_csum", 64'(done), 64'd0);
    send_byte(frame_csum() ^ flip);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: good two-word frame.
    wen_count = 0;
    pulse_start();
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_hold", 64'(core_hold), 64'd1);
    send_frame1(8'h00, -1);
    check("t1_done",   64'(done), 64'd1);
    check("t1_error",  64'(error), 64'd0);
    check("t1_hold",   64'(core_hold), 64'd0);
    check("t1_busy",   64'(busy), 64'd0);
    check("t1_writes", 64'(wen_count), 64'd2);
    check("t1_sb",     64'(exp_q.size()), 64'd0);

    // Test 2: corrupted checksum, then START clears ERROR.
    wen_count = 0;
    pulse_start();
    check("t2_done_cleared", 64'(done), 64'd0);
    send_frame1(8'h01, -1);
    check("t2_error",  64'(error), 64'd1);
    check("t2_done",   64'(done), 64'd0);
    check("t2_hold",   64'(core_hold), 64'd1);
    check("t2_writes", 64'(wen_count), 64'd2);
    pulse_start();
    check("t2_error_clr", 64'(error), 64'd0);
    check("t2_busy",      64'(busy), 64'd1);

    // Test 3: garbage before the marker, empty frame.
    wen_count = 0;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    check("t3_done",   64'(done), 64'd1);
    check("t3_hold",   64'(core_hold), 64'd0);
    check("t3_writes", 64'(wen_count), 64'd0);

    // Test 4: oversize count fails right after CNT_HI.
    wen_count = 0;
    pulse_start();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h0E);
    check("t4_error",    64'(error), 64'd1);
    check("t4_rx_ready", 64'(rx_ready), 64'd0);
    check("t4_hold",     64'(core_hold), 64'd1);
    repeat (3) @(negedge clk);
    check("t4_writes",   64'(wen_count), 64'd0);

    // Count exactly filling the memory is accepted; then abort by reset.
    pulse_start();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h0E);
    check("max_error",    64'(error), 64'd0);
    check("max_rx_ready", 64'(rx_ready), 64'd1);
    check("max_w_addr",   64'(w_addr), 64'h200);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle("max_reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Test 5: random RX gaps, reset during the third data byte.
    rand_gaps = 1'b1;
    wen_count = 0;
    pulse_start();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h13);
    send_byte(8'h05);
    rx_data  = 8'h15;
    rx_valid = 1'b1;
    rst_n    = 1'b0;
    @(negedge clk);
    rx_valid = 1'b0;
    check_idle("t5_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_no_wen", 64'(wen_count), 64'd0);
    pulse_start();
    send_frame1(8'h00, -1);
    check("t5_done",   64'(done), 64'd1);
    check("t5_writes", 64'(wen_count), 64'd2);
    check("t5_sb",     64'(exp_q.size()), 64'd0);
    rand_gaps = 1'b0;

    // Test 6: START mid-frame is ignored.
    wen_count = 0;
    pulse_start();
    send_frame1(8'h00, 5);
    check("t6_done",   64'(done), 64'd1);
    check("t6_error",  64'(error), 64'd0);
    check("t6_writes", 64'(wen_count), 64'd2);
    check("t6_sb",     64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
